// File: rtl/p2s_pkg.sv
// Shared types and helpers for the parallel-to-serial chain driver.
package p2s_pkg;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      LOAD,
      SHIFT,
      LATCH
   } state_e;

   // Prescaler counter width for a given half-period divider.
   function automatic int unsigned prescale_width(input int unsigned div);
      return $clog2(div + 1);
   endfunction

endpackage

// File: rtl/p2s_prescaler.sv
// Half-period prescaler: ticks on the last cycle of every CLK_DIV-cycle phase while enabled.
module p2s_prescaler
   import p2s_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic phase_end_c,
   output logic near_end_c
);

   localparam int unsigned CW   = prescale_width(CLK_DIV);
   localparam int unsigned LAST = CLK_DIV - 1;
   localparam int unsigned NEAR = (CLK_DIV > 1) ? CLK_DIV - 2 : 0;

   logic [CW-1:0] cnt_q, cnt_d;

   // near_end_c flags that the following cycle will end the phase
   assign phase_end_c = en_i && (cnt_q == CW'(LAST));
   assign near_end_c  = en_i && ((CLK_DIV == 1) || (cnt_q == CW'(NEAR)));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!en_i || phase_end_c) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/p2s_chain.sv
// Parallel-to-serial driver for daisy-chained shift registers with busy/done
// handshake, one-deep pending request and a power-on clear sequence.
module p2s_chain
   import p2s_pkg::*;
#(
   parameter int unsigned DATA_BITS = 64,
   parameter int unsigned CNT_BITS  = 6,
   parameter int unsigned CLK_DIV   = 4,
   parameter bit          LSB_FIRST = 1'b0
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data,
   output logic                 busy,
   output logic                 done,
   output logic                 s_clk,
   output logic                 s_out,
   output logic                 s_clrn,
   output logic                 s_pen
);

   if (((2 ** CNT_BITS) < DATA_BITS) || (DATA_BITS < 2) || (CLK_DIV < 1)) begin : g_param_chk
      $error("p2s_chain: illegal DATA_BITS/CNT_BITS/CLK_DIV combination");
   end

   state_e               state_q, state_d;
   logic                 phase_q, phase_d;
   logic [CNT_BITS-1:0]  bitcnt_q, bitcnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 pending_q, pending_d;
   logic                 start_q;
   logic                 busy_q, busy_d, done_q, done_d;
   logic                 s_clk_q, s_clk_d, s_out_q, s_out_d;
   logic                 s_clrn_q, s_clrn_d, s_pen_q, s_pen_d;
   logic                 trig, pre_en, phase_end, near_end;

   assign trig   = start & ~start_q;
   assign pre_en = (state_q == CLEAR) || (state_q == SHIFT) || (state_q == LATCH);

   p2s_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (
      .clk         (clk),
      .rst         (rst),
      .en_i        (pre_en),
      .phase_end_c (phase_end),
      .near_end_c  (near_end)
   );

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         phase_q   <= 1'b0;
         bitcnt_q  <= '0;
         shreg_q   <= '0;
         pending_q <= 1'b0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         s_clk_q   <= 1'b1;
         s_out_q   <= 1'b0;
         s_clrn_q  <= 1'b0;
         s_pen_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         pending_q <= pending_d;
         start_q   <= start;
         busy_q    <= busy_d;
         done_q    <= done_d;
         s_clk_q   <= s_clk_d;
         s_out_q   <= s_out_d;
         s_clrn_q  <= s_clrn_d;
         s_pen_q   <= s_pen_d;
      end
   end

   // Next-state logic; phase_q is the half select in CLEAR and the s_clk phase in SHIFT
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      pending_d = pending_q | (trig && (state_q != IDLE));
      case (state_q)
         CLEAR: begin
            if (phase_end) begin
               phase_d = ~phase_q;
               if (phase_q) state_d = IDLE;
            end
         end
         IDLE: begin
            if (trig || pending_q) begin
               state_d   = LOAD;
               pending_d = 1'b0;
            end
         end
         LOAD: begin
            shreg_d  = data;
            bitcnt_d = CNT_BITS'(DATA_BITS - 1);
            phase_d  = 1'b0;
            state_d  = SHIFT;
         end
         SHIFT: begin
            if (phase_end) begin
               phase_d = ~phase_q;
               if (phase_q) begin
                  shreg_d = LSB_FIRST ? {1'b0, shreg_q[DATA_BITS-1:1]}
                                      : {shreg_q[DATA_BITS-2:0], 1'b0};
                  if (bitcnt_q == '0) state_d = LATCH;
                  else                bitcnt_d = bitcnt_q - CNT_BITS'(1);
               end
            end
         end
         LATCH: begin
            if (phase_end) begin
               // an edge in the done cycle queues behind the request consumed here
               pending_d = trig;
               state_d   = pending_q ? LOAD : IDLE;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q
   always_comb begin
      busy_d   = (state_d == LOAD) || (state_d == SHIFT) || (state_d == LATCH);
      done_d   = (state_d == LATCH) && ((state_q == LATCH) ? near_end : (CLK_DIV == 1));
      s_clk_d  = !((state_d == SHIFT) && !phase_d);
      s_out_d  = (state_d == SHIFT) && (LSB_FIRST ? shreg_d[0] : shreg_d[DATA_BITS-1]);
      s_clrn_d = (state_d != CLEAR);
      s_pen_d  = (state_d == IDLE) || (state_d == LATCH);
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign s_clk  = s_clk_q;
   assign s_out  = s_out_q;
   assign s_clrn = s_clrn_q;
   assign s_pen  = s_pen_q;

endmodule
